// File: rtl/msf_pkg.sv
// MSF input conditioner shared definitions.
// Clock/filter defaults and the lock state type.
package msf_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 12500;
  localparam int unsigned FILTER_LEN_DEF = 16;

  typedef enum logic {
    LOST = 1'b0,
    OK   = 1'b1
  } msf_state_e;

endpackage

// File: rtl/msf_input_conditioner_if.sv
// Signal bundle between an MSF receiver front end
// and the input conditioner.
interface msf_input_conditioner_if;
  import msf_pkg::*;

  logic       data_i;
  logic       invert_i;
  logic       data_o;
  logic       rise_o;
  logic       fall_o;
  logic       signal_ok_o;
  logic [7:0] glitch_cnt_o;

  modport master (
    output data_i, invert_i,
    input  data_o, rise_o, fall_o,
    input  signal_ok_o, glitch_cnt_o
  );

  modport slave (
    input  data_i, invert_i,
    output data_o, rise_o, fall_o,
    output signal_ok_o, glitch_cnt_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit,
// synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/msf_input_conditioner.sv
// MSF carrier conditioner: sync, glitch integrator with
// hysteresis, edge pulses and a lock/loss monitor.
module msf_input_conditioner
  import msf_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = CLK_FREQ_DEF,
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF,
  parameter int unsigned LOSS_TIMEOUT_S = 3,
  parameter int unsigned LOCK_EDGES     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  input  logic       invert_i,
  output logic       data_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       signal_ok_o,
  output logic [7:0] glitch_cnt_o
);

  localparam int unsigned TIMEOUT = LOSS_TIMEOUT_S * CLK_FREQ;
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = $clog2(LOCK_EDGES + 1);

  localparam logic [CW-1:0] FULL = CW'(FILTER_LEN);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [EW-1:0] LAST = EW'(LOCK_EDGES - 1);

  logic          sync_w, s_w;
  logic [CW-1:0] cnt_q, cnt_d, home_w;
  logic          data_q, data_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [7:0]    glitch_q, glitch_d;
  logic [TW-1:0] to_q, to_d;
  logic [EW-1:0] ec_q, ec_d;
  logic          edge_w, hit_w;
  msf_state_e    state_q, state_d;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (data_i),
    .q_o   (sync_w)
  );

  assign s_w    = sync_w ^ invert_i;
  assign home_w = data_q ? FULL : '0;

  always_comb begin
    cnt_d    = cnt_q;
    data_d   = data_q;
    glitch_d = glitch_q;
    to_d     = to_q;
    if (s_w && cnt_q != FULL) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!s_w && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (cnt_d == FULL) begin
      data_d = 1'b1;
    end else if (cnt_d == '0) begin
      data_d = 1'b0;
    end
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
    edge_w = rise_d | fall_d;
    // An excursion that falls back to the held level is a glitch
    if (cnt_q != '0 && cnt_q != FULL &&
        cnt_d == home_w && glitch_q != 8'hFF) begin
      glitch_d = glitch_q + 8'd1;
    end
    if (edge_w) begin
      to_d = '0;
    end else if (to_q != TMAX) begin
      to_d = to_q + TW'(1);
    end
    hit_w = (to_d == TMAX);
  end

  always_comb begin
    state_d = state_q;
    ec_d    = ec_q;
    unique case (state_q)
      LOST: begin
        if (edge_w) begin
          if (ec_q == LAST) begin
            state_d = OK;
            ec_d    = '0;
          end else begin
            ec_d = ec_q + EW'(1);
          end
        end else if (hit_w) begin
          ec_d = '0;
        end
      end
      OK: begin
        if (!edge_w && hit_w) begin
          state_d = LOST;
          ec_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      data_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
      to_q     <= '0;
      ec_q     <= '0;
      state_q  <= LOST;
    end else begin
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      to_q     <= to_d;
      ec_q     <= ec_d;
      state_q  <= state_d;
    end
  end

  assign data_o       = data_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign signal_ok_o  = (state_q == OK);
  assign glitch_cnt_o = glitch_q;

endmodule
